obi_periph_arb: RTL

- Round-robin arbiter that shares one OBI peripheral slave port (e.g. the GPIO block) between NUM_MST OBI requesters, such as the core data port and the debug module.
- Issues one transaction at a time to the slave and routes the response (rvalid/rdata) back to the requester that owns the transaction.
- Sits between the bus crossbar master side and the peripheral's OBI slave.
- Includes a response timeout, so a hung slave cannot lock up the bus.

---
 rtl/obi_arb_pkg.sv | 26 ++
 rtl/obi_periph_arb_rr_pick.sv | 43 ++++
 rtl/obi_periph_arb.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/obi_arb_pkg.sv
// -----------------------------------------------------------------------------
// obi_arb_pkg
// Shared types and constants for the OBI peripheral arbiter.
//   obi_req_t     : request fields forwarded from the winning requester to the
//                   slave (we, be, addr, wdata)
//   arb_state_e   : arbiter FSM state (IDLE, WAIT, ERR)
//   OBI_ERR_RDATA : read data returned with a timeout error response
// -----------------------------------------------------------------------------
package obi_arb_pkg;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } arb_state_e;

    localparam logic [31:0] OBI_ERR_RDATA = 32'h0;

endpackage

// File: rtl/obi_periph_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Scans req_i upward starting at
// ptr_i, wrapping at N, and reports the first set bit.
//   req_i    : request vector
//   ptr_i    : highest-priority index for this cycle (must be < N)
//   winner_o : index of the selected request (0 when none is set)
//   any_o    : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] winner_o,
    output logic          any_o
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [PW:0] idx;
    logic        found;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr_i} + (PW+1)'(i);
            // ptr < N and i < N, so a single subtraction completes the wrap.
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req_i[idx[PW-1:0]]) begin
                found    = 1'b1;
                winner_o = idx[PW-1:0];
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/obi_periph_arb.sv
// -----------------------------------------------------------------------------
// obi_periph_arb
// Round-robin arbiter sharing one OBI peripheral slave between NUM_MST OBI
// requesters. At most one transaction is outstanding; its response is routed
// back to the requester that owns it. A slave that stays silent for
// TIMEOUT_CYCLES cycles produces a one-cycle error response instead.
//
// Ports
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   m_req_i/we/be/addr/wdata : per-requester OBI request channel
//   m_gnt_o            : per-requester grant (one-hot or zero)
//   m_rvalid_o         : per-requester response valid (one-hot or zero)
//   m_err_o            : qualifies m_rvalid_o, 1 = timeout error
//   m_rdata_o          : response data, broadcast to all requesters
//   s_req_o/we/be/addr/wdata : OBI request channel towards the slave
//   s_gnt_i, s_rvalid_i, s_rdata_i : slave grant and response
// -----------------------------------------------------------------------------
module obi_periph_arb
    import obi_arb_pkg::*;
#(
    parameter  int NUM_MST        = 2,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int MSTW           = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic [NUM_MST-1:0]         m_req_i,
    input  logic [NUM_MST-1:0]         m_we_i,
    input  logic [NUM_MST-1:0][3:0]    m_be_i,
    input  logic [NUM_MST-1:0][31:0]   m_addr_i,
    input  logic [NUM_MST-1:0][31:0]   m_wdata_i,
    output logic [NUM_MST-1:0]         m_gnt_o,
    output logic [NUM_MST-1:0]         m_rvalid_o,
    output logic                       m_err_o,
    output logic [31:0]                m_rdata_o,

    output logic                       s_req_o,
    output logic                       s_we_o,
    output logic [3:0]                 s_be_o,
    output logic [31:0]                s_addr_o,
    output logic [31:0]                s_wdata_o,
    input  logic                       s_gnt_i,
    input  logic                       s_rvalid_i,
    input  logic [31:0]                s_rdata_i
);

    arb_state_e        state_q, state_d;
    logic [MSTW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [MSTW-1:0]   owner_q, owner_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;

    logic [MSTW-1:0]   winner;
    logic              any_req;
    logic              issue_ok;
    logic              grant;
    logic              rsp_ok;
    obi_req_t          win_req;
    logic [NUM_MST-1:0] winner_oh;
    logic [NUM_MST-1:0] owner_oh;

    rr_pick #(
        .N (NUM_MST)
    ) u_rr_pick (
        .req_i    (m_req_i),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    // A new request may only go out while nothing is outstanding, or in the
    // very cycle the outstanding response returns (back-to-back issue).
    assign issue_ok = (state_q == IDLE) || ((state_q == WAIT) && s_rvalid_i);
    assign rsp_ok   = (state_q == WAIT) && s_rvalid_i;

    always_comb begin
        win_req.we    = m_we_i[winner];
        win_req.be    = m_be_i[winner];
        win_req.addr  = m_addr_i[winner];
        win_req.wdata = m_wdata_i[winner];
    end

    always_comb begin
        winner_oh         = '0;
        winner_oh[winner] = 1'b1;
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Slave request channel
    always_comb begin
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        if (issue_ok) begin
            s_req_o   = any_req;
            s_we_o    = win_req.we;
            s_be_o    = win_req.be;
            s_addr_o  = win_req.addr;
            s_wdata_o = win_req.wdata;
        end
    end

    assign grant   = s_req_o & s_gnt_i;
    assign m_gnt_o = grant ? winner_oh : '0;

    // Response channel: a real response in WAIT, or the synthetic error in ERR.
    // A late slave response in IDLE/ERR never reaches a requester.
    always_comb begin
        m_rvalid_o = '0;
        m_err_o    = 1'b0;
        m_rdata_o  = OBI_ERR_RDATA;
        if (rsp_ok) begin
            m_rvalid_o = owner_oh;
            m_rdata_o  = s_rdata_i;
        end else if (state_q == ERR) begin
            m_rvalid_o = owner_oh;
            m_err_o    = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        tmo_cnt_d = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (s_rvalid_i) begin
                    state_d = grant ? WAIT : IDLE;
                end else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant) begin
            owner_d   = winner;
            tmo_cnt_d = '0;
            rr_ptr_d  = (winner == MSTW'(NUM_MST - 1)) ? '0 : winner + MSTW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule
